// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between branch issue/resolve logic and the resolve queue.
// master: drives predictions and resolutions; slave: returns predictor training pulses.
interface branch_resolve_queue_if;
    logic pred_valid;
    logic pred_taken;
    logic res_valid;
    logic res_taken;
    logic upd_result;
    logic upd_taken;
    logic mispredict;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  upd_result, upd_taken, mispredict
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output upd_result, upd_taken, mispredict
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions; trains the 2-bit predictor on resolve
// and flushes wrong-path entries on a mispredict. Optional stats under BRQ_STATS_EN.
// Ports: clk, reset (sync, active-high), brq (slave: pred_*/res_* in, upd_*/mispredict out),
//        full, empty, count, overflow, underflow (sticky), resolved_cnt, mispred_cnt.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    branch_resolve_queue_if.slave      brq,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    output logic [CNT_W-1:0]           resolved_cnt,
    output logic [CNT_W-1:0]           mispred_cnt
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so occupancy is simply wr - rd.
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [DEPTH-1:0] mem;
    logic             head;
    logic             pop;
    logic             squash;
    logic             push;
    logic             upd_result_q;
    logic             upd_taken_q;
    logic             mispredict_q;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    assign pop    = brq.res_valid & ~empty;
    assign squash = pop & (head != brq.res_taken);
    // A full queue still accepts when a correct pop frees the head slot this edge.
    assign push   = brq.pred_valid & (~full | pop) & ~squash;

    assign brq.upd_result = upd_result_q;
    assign brq.upd_taken  = upd_taken_q;
    assign brq.mispredict = mispredict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            upd_result_q <= 1'b0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            upd_result_q <= pop;
            upd_taken_q  <= pop & brq.res_taken;
            mispredict_q <= squash;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Squash empties the queue: wr lands where rd lands after the pop.
            if (squash)
                wr_ptr <= rd_ptr + 1'b1;
            else if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (brq.pred_valid & full & ~brq.res_valid)
                overflow <= 1'b1;
            if (brq.res_valid & empty)
                underflow <= 1'b1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr[AW-1:0]] <= brq.pred_taken;
    end

`ifdef BRQ_STATS_EN
    localparam logic [CNT_W-1:0] CMAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else begin
            if (pop && resolved_cnt != CMAX)
                resolved_cnt <= resolved_cnt + 1'b1;
            if (squash && mispred_cnt != CMAX)
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end
`else
    assign resolved_cnt = '0;
    assign mispred_cnt  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based model.
// Stats checks follow BRQ_STATS_EN; narrow CNT_W makes counter saturation reachable.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic full, empty, overflow, underflow;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0] resolved_cnt, mispred_cnt;

    branch_resolve_queue_if brq_if ();

    branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .brq(brq_if),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .resolved_cnt(resolved_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    bit q[$];
    bit m_ovf, m_unf, m_upd, m_ut, m_mis;
    int m_res, m_misc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), q.size() == 0);
        chk("full", 32'(full), q.size() == DEPTH);
        chk("upd_result", 32'(brq_if.upd_result), m_upd);
        chk("upd_taken", 32'(brq_if.upd_taken), m_ut);
        chk("mispredict", 32'(brq_if.mispredict), m_mis);
        chk("overflow", 32'(overflow), m_ovf);
        chk("underflow", 32'(underflow), m_unf);
`ifdef BRQ_STATS_EN
        chk("resolved_cnt", 32'(resolved_cnt), m_res);
        chk("mispred_cnt", 32'(mispred_cnt), m_misc);
`else
        chk("resolved_cnt", 32'(resolved_cnt), 0);
        chk("mispred_cnt", 32'(mispred_cnt), 0);
`endif
    endtask

    // One clock: drive strobes, advance the model, check after the edge.
    task automatic step(input bit rst, input bit pv, input bit pt, input bit rv, input bit rt);
        int  pre;
        bit  hd;
        bit  sq;
        reset = rst;
        brq_if.pred_valid = pv;
        brq_if.pred_taken = pt;
        brq_if.res_valid  = rv;
        brq_if.res_taken  = rt;
        m_upd = 0;
        m_ut  = 0;
        m_mis = 0;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_res = 0;
            m_misc = 0;
        end else begin
            pre = q.size();
            sq = 0;
            if (rv) begin
                if (pre == 0) begin
                    m_unf = 1;
                end else begin
                    hd = q.pop_front();
                    m_upd = 1;
                    m_ut = rt;
                    sq = (hd != rt);
                    m_mis = sq;
                    if (m_res < CMAX) m_res++;
                    if (sq) begin
                        q.delete();
                        if (m_misc < CMAX) m_misc++;
                    end
                end
            end
            if (pv && !sq) begin
                if (pre == DEPTH && !rv) m_ovf = 1;
                else q.push_back(pt);
            end
        end
        @(posedge clk);
        #1;
        check_all();
        reset = 0;
        brq_if.pred_valid = 0;
        brq_if.res_valid  = 0;
    endtask

    initial begin
        bit b;
        brq_if.pred_valid = 0;
        brq_if.pred_taken = 0;
        brq_if.res_valid  = 0;
        brq_if.res_taken  = 0;
        #2;

        // Reset then enqueue T,T,N
        step(1, 0, 0, 0, 0);
        chk("rst_empty", 32'(empty), 1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t1_count", 32'(count), 3);

        // Resolve 1,1,0 all correct
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("t2_upd_taken", 32'(brq_if.upd_taken), 0);
        step(0, 0, 0, 0, 0);
        chk("t2_empty", 32'(empty), 1);

        // Mispredict squash then underflow
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t3_mis", 32'(brq_if.mispredict), 1);
        chk("t3_count", 32'(count), 0);
        step(0, 0, 0, 1, 1);
        chk("t3_unf", 32'(underflow), 1);

        // Overflow, then full accept with correct pop
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i[0], 0, 0);
        step(0, 1, 1, 0, 0);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_count", 32'(count), 4);
        step(0, 1, 1, 1, 0);
        chk("t4_count2", 32'(count), 4);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("t4_last", 32'(brq_if.upd_taken), 1);
        chk("t4_last_mis", 32'(brq_if.mispredict), 0);

        // Pointer wrap, 10 correct pairs
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            b = ~i[0];
            step(0, 1, b, 0, 0);
            step(0, 0, 0, 1, b);
        end

        // Reset at count 3, then mispredict saturation
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_upd", 32'(brq_if.upd_result), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 0);
            step(0, 0, 0, 1, 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit rv;
            bit rt;
            rv = ($urandom % 3) == 0;
            rt = $urandom % 2;
            if (q.size() > 0 && ($urandom % 4) != 0) rt = q[0];
            step(($urandom % 100) == 0, ($urandom % 2) == 1, $urandom % 2, rv, rt);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
